alu_res_collector: RTL and testbench



---
 rtl/alu_res_pkg.sv | 32 +++
 rtl/res_sync_fifo.sv | 63 ++++++
 rtl/alu_res_collector.sv | 146 ++++++++++++++
 tb/tb_alu_res_collector.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_res_pkg.sv
// rtl/alu_res_pkg.sv - shared constants and helpers for the ALU result collector
//
// Purpose: source encodings, result-width computation and entry field offsets
// for alu_res_collector and its result FIFO.
package alu_res_pkg;

    localparam logic SRC_MUL = 1'b0;
    localparam logic SRC_ADD = 1'b1;

    // Result word is {id, carry, result}.
    function automatic int calc_res_w(input int data_size, input int id_size);
        return data_size + 1 + id_size;
    endfunction

    // Field offsets inside a FIFO entry {src, id, carry, result}.
    function automatic int result_lsb();
        return 0;
    endfunction

    function automatic int carry_pos(input int data_size);
        return data_size;
    endfunction

    function automatic int id_lsb(input int data_size);
        return data_size + 1;
    endfunction

    function automatic int src_pos(input int data_size, input int id_size);
        return calc_res_w(data_size, id_size);
    endfunction

endpackage

// File: rtl/res_sync_fifo.sv
// rtl/res_sync_fifo.sv - first-word-fall-through synchronous result FIFO
//
// Purpose: DEPTH x WIDTH FIFO whose head is always visible on pop_data.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     write request and entry (ignored when full)
//   pop                 remove head entry (ignored when empty)
//   pop_data            head entry (don't-care when empty)
//   full, empty, count  status derived from the pointers
module res_sync_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign count    = wr_ptr_q - rd_ptr_q;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only observed after it is written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/alu_res_collector.sv
// rtl/alu_res_collector.sv - round-robin capture of mul/add results into a result FIFO
//
// Purpose: holds one pending result per execution unit, grants one per cycle
// round-robin while the FIFO has space, and writes {src, id, carry, result}.
// Optional macro ALU_RES_OVF_CHECK_EN enables the sticky overrun flag ovf_err.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   m_valid_res, result_mul, mul_written multiplier capture and write acknowledge
//   a_valid_res, result_add, add_written adder capture and write acknowledge
//   ready_f_res                         FIFO not full
//   rd_en, res_out, res_valid, count    consumer side of the result FIFO
//   ovf_err                             sticky capture-overrun flag
module alu_res_collector
    import alu_res_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int ID_SIZE   = 8,
    parameter int DEPTH     = 8,
    localparam int RES_W    = calc_res_w(DATA_SIZE, ID_SIZE),
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             m_valid_res,
    input  logic [RES_W-1:0] result_mul,
    output logic             mul_written,
    input  logic             a_valid_res,
    input  logic [RES_W-1:0] result_add,
    output logic             add_written,
    output logic             ready_f_res,
    input  logic             rd_en,
    output logic [RES_W:0]   res_out,
    output logic             res_valid,
    output logic [CNT_W-1:0] count,
    output logic             ovf_err
);

    logic             pend_mul_q, pend_mul_d;
    logic             pend_add_q, pend_add_d;
    logic [RES_W-1:0] data_mul_q, data_mul_d;
    logic [RES_W-1:0] data_add_q, data_add_d;
    logic             last_grant_q, last_grant_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             wr_ok;
    logic             grant_mul;
    logic             grant_add;
    logic             push;
    logic [RES_W:0]   push_data;

    // Occupancy at the start of the cycle decides; a same-cycle pop does not help.
    assign wr_ok = !fifo_full;

    // A tie goes to the source that did not win last time.
    assign grant_mul = wr_ok && pend_mul_q && (!pend_add_q || (last_grant_q == SRC_ADD));
    assign grant_add = wr_ok && pend_add_q && (!pend_mul_q || (last_grant_q == SRC_MUL));

    assign push      = grant_mul || grant_add;
    assign push_data = grant_mul ? {SRC_MUL, data_mul_q} : {SRC_ADD, data_add_q};

    assign mul_written = grant_mul;
    assign add_written = grant_add;
    assign ready_f_res = !fifo_full;
    assign res_valid   = !fifo_empty;

    always_comb begin
        pend_mul_d   = pend_mul_q;
        pend_add_d   = pend_add_q;
        data_mul_d   = data_mul_q;
        data_add_d   = data_add_q;
        last_grant_d = last_grant_q;

        if (grant_mul) begin
            pend_mul_d   = 1'b0;
            last_grant_d = SRC_MUL;
        end
        if (grant_add) begin
            pend_add_d   = 1'b0;
            last_grant_d = SRC_ADD;
        end

        // New capture wins over the clear: the granted old data is written
        // this cycle while the new data stays pending.
        if (m_valid_res) begin
            pend_mul_d = 1'b1;
            data_mul_d = result_mul;
        end
        if (a_valid_res) begin
            pend_add_d = 1'b1;
            data_add_d = result_add;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_mul_q   <= 1'b0;
            pend_add_q   <= 1'b0;
            data_mul_q   <= '0;
            data_add_q   <= '0;
            last_grant_q <= SRC_ADD;
        end else begin
            pend_mul_q   <= pend_mul_d;
            pend_add_q   <= pend_add_d;
            data_mul_q   <= data_mul_d;
            data_add_q   <= data_add_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef ALU_RES_OVF_CHECK_EN
    logic ovf_q, ovf_d;

    // Overrun: fresh data arrives while the previous one is still waiting.
    always_comb begin
        ovf_d = ovf_q
              | (m_valid_res && pend_mul_q && !grant_mul)
              | (a_valid_res && pend_add_q && !grant_add);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign ovf_err = ovf_q;
`else
    assign ovf_err = 1'b0;
`endif

    res_sync_fifo #(
        .WIDTH (RES_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (rd_en),
        .pop_data  (res_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

endmodule

// File: tb/tb_alu_res_collector.sv
// tb/tb_alu_res_collector.sv - scoreboard bench for alu_res_collector
module tb_alu_res_collector;

    localparam int DS    = 16;
    localparam int IW    = 8;
    localparam int DEPTH = 8;
    localparam int RW    = DS + 1 + IW;
    localparam int EW    = RW + 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m_valid_res = 1'b0;
    logic [RW-1:0] result_mul = '0;
    logic          mul_written;
    logic          a_valid_res = 1'b0;
    logic [RW-1:0] result_add = '0;
    logic          add_written;
    logic          ready_f_res;
    logic          rd_en = 1'b0;
    logic [EW-1:0] res_out;
    logic          res_valid;
    logic [CW-1:0] count;
    logic          ovf_err;

    always #5 clk = ~clk;

    alu_res_collector #(.DATA_SIZE(DS), .ID_SIZE(IW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_valid_res (m_valid_res),
        .result_mul  (result_mul),
        .mul_written (mul_written),
        .a_valid_res (a_valid_res),
        .result_add  (result_add),
        .add_written (add_written),
        .ready_f_res (ready_f_res),
        .rd_en       (rd_en),
        .res_out     (res_out),
        .res_valid   (res_valid),
        .count       (count),
        .ovf_err     (ovf_err)
    );

    typedef struct {
        bit mw;
        bit aw;
        int cnt;
        bit ovf;
    } st_t;

    st_t           st_q[$];
    logic [EW-1:0] exp_q[$];

    // Reference model: FIFO contents as a queue, one optional pending value per source.
    logic [EW-1:0] m_fifo[$];
    bit            m_pm, m_pa, m_last_add, m_ovf;
    logic [RW-1:0] m_dm, m_da;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] mk(input int id, input bit c, input int r);
        logic [RW-1:0] v;
        v = {8'(id), c, 16'(r)};
        return v;
    endfunction

    function automatic logic [RW-1:0] rnd();
        logic [RW-1:0] v;
        v = RW'($urandom());
        return v;
    endfunction

    // Called just after a rising edge; drives one cycle of inputs and advances the model.
    task automatic step(input bit mv, input logic [RW-1:0] md, input bit av,
                        input logic [RW-1:0] ad, input bit rd, input bit rst);
        st_t e;
        bit  full, gm, ga, ovf_ev;
        ovf_ev = 0;
        if (rst) begin
            rst_n = 1'b0;
            m_fifo.delete();
            exp_q.delete();
            m_pm = 0; m_pa = 0; m_dm = '0; m_da = '0; m_last_add = 1; m_ovf = 0;
            mv = 0; av = 0; rd = 0;
            #1;
            chk("reset_count", 64'(count), 64'd0);
            chk("reset_res_valid", 64'(res_valid), 64'd0);
            chk("reset_ready", 64'(ready_f_res), 64'd1);
        end else begin
            rst_n = 1'b1;
        end

        full = (m_fifo.size() == DEPTH);
        gm = !full && m_pm && (!m_pa || m_last_add);
        ga = !full && m_pa && (!m_pm || !m_last_add);
        e.mw = gm; e.aw = ga; e.cnt = m_fifo.size(); e.ovf = m_ovf;
        st_q.push_back(e);

        m_valid_res = mv; result_mul = md;
        a_valid_res = av; result_add = ad;
        rd_en = rd;

        if (rd && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (gm) begin
            m_fifo.push_back({1'b0, m_dm});
            exp_q.push_back({1'b0, m_dm});
            m_last_add = 0;
        end
        if (ga) begin
            m_fifo.push_back({1'b1, m_da});
            exp_q.push_back({1'b1, m_da});
            m_last_add = 1;
        end
        if (mv) begin
            if (m_pm && !gm) ovf_ev = 1;
            m_pm = 1; m_dm = md;
        end else if (gm) m_pm = 0;
        if (av) begin
            if (m_pa && !ga) ovf_ev = 1;
            m_pa = 1; m_da = ad;
        end else if (ga) m_pa = 0;
`ifdef ALU_RES_OVF_CHECK_EN
        if (ovf_ev) m_ovf = 1;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, 0);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, 1, 0);
    endtask

    // Monitor: per-cycle status from the state queue, data checked on every pop.
    initial begin
        st_t e;
        logic [EW-1:0] x;
        forever begin
            @(negedge clk);
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                chk("mul_written", 64'(mul_written), 64'(e.mw));
                chk("add_written", 64'(add_written), 64'(e.aw));
                chk("count", 64'(count), 64'(e.cnt));
                chk("ready_f_res", 64'(ready_f_res), 64'(e.cnt != DEPTH));
                chk("res_valid", 64'(res_valid), 64'(e.cnt != 0));
                chk("ovf_err", 64'(ovf_err), 64'(e.ovf));
            end
            if (rd_en && res_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL res_out: got %0h expected none (scoreboard empty)", res_out);
                end else begin
                    x = exp_q.pop_front();
                    chk("res_out", 64'(res_out), 64'(x));
                end
            end
        end
    end

    initial begin
        m_pm = 0; m_pa = 0; m_dm = '0; m_da = '0; m_last_add = 1; m_ovf = 0;
        repeat (2) @(posedge clk);
        #1;
        step(0, '0, 0, '0, 0, 1);
        step(0, '0, 0, '0, 0, 1);
        idle(1);

        // Single mul result
        step(1, mk(8'h3A, 0, 16'h0C35), 0, '0, 0, 0);
        idle(1);
        chk("single_res_out", 64'(res_out), 64'h0740C35);
        chk("single_res_valid", 64'(res_valid), 64'd1);
        pop_n(1);
        idle(1);

        // Simultaneous results: mul wins first tie
        step(1, mk(1, 0, 16'h1111), 1, mk(2, 1, 16'h2222), 0, 0);
        idle(3);
        pop_n(2);
        // Lone mul makes MUL the last grant, so the next tie goes to add
        step(1, mk(9, 0, 16'h9999), 0, '0, 0, 0);
        idle(2);
        pop_n(1);
        step(1, mk(1, 1, 16'h3333), 1, mk(2, 0, 16'h4444), 0, 0);
        idle(3);
        pop_n(3);

        // Full FIFO stalls a mul result until a pop
        for (int i = 0; i < DEPTH; i++) step(0, '0, 1, rnd(), 0, 0);
        idle(2);
        step(1, rnd(), 0, '0, 0, 0);
        idle(3);
        pop_n(1);
        idle(3);

        // Overrun while full: only the second mul (id 6) survives
        step(1, mk(5, 0, 16'h0005), 0, '0, 0, 0);
        step(1, mk(6, 0, 16'h0006), 0, '0, 0, 0);
        idle(2);
        pop_n(1);
        idle(3);
        pop_n(DEPTH + 3);

        // Wrap: 20 entries with reads interleaved, then reads past empty
        for (int i = 0; i < 20; i++) step(1, rnd(), 0, '0, (i >= 2), 0);
        pop_n(25);

        // Randomized traffic
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 2) == 0, rnd(), $urandom_range(0, 2) == 0, rnd(),
                 $urandom_range(0, 3) != 0, 0);
        pop_n(DEPTH + 4);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // Reset with three stored entries and a pending add
        for (int i = 0; i < 3; i++) step(0, '0, 1, rnd(), 0, 0);
        idle(2);
        step(0, '0, 1, rnd(), 0, 0);
        step(0, '0, 0, '0, 0, 1);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
